frequency_meter: RTL and testbench

- Measures the frequency of a slow digital signal, such as a ClockGenerator output or a GPIO input, by counting its rising edges over a fixed gate window of system clocks.
- The reading side of the clock generators: turns a clock back into a number.
- Output feeds segmentDisplay_DisplayValue, so a generated clock can be checked on the 7-segment display.
- Continuous back-to-back windows with no dead time between them.

---
 rtl/frequency_meter.sv | 113 +++++++++++
 tb/tb_frequency_meter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_meter.sv
// Counts rising edges of an asynchronous input over back-to-back gate windows of
// GATE_CYCLES system clocks and reports the saturated count once per window.
module frequency_meter #(
   parameter int unsigned INPUT_CLOCK_SPEED = 50000000,
   parameter int unsigned GATE_CYCLES       = INPUT_CLOCK_SPEED,
   parameter int unsigned COUNT_WIDTH       = 20,
   parameter int unsigned MAX_VALUE         = 999999
) (
   input  logic                   inputClock,
   input  logic                   reset,
   input  logic                   measuredSignal,
   input  logic                   enable,
   output logic [COUNT_WIDTH-1:0] frequencyValue,
   output logic                   valid,
   output logic                   overflow,
   output logic                   measuring
);

   localparam int unsigned GateWidth = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GateWidth-1:0]  GateLast = GateWidth'(GATE_CYCLES - 1);
   localparam logic [COUNT_WIDTH:0]  MaxExt   = (COUNT_WIDTH + 1)'(MAX_VALUE);

   typedef enum logic {
      StIdle,
      StCount
   } state_t;

   state_t                 r_state;
   logic                   r_sync1;
   logic                   r_sync2;
   logic                   r_prev;
   logic [GateWidth-1:0]   r_gate_cnt;
   logic [COUNT_WIDTH-1:0] r_edge_cnt;
   logic                   r_win_ovf;
   logic [COUNT_WIDTH-1:0] r_freq;
   logic                   r_valid;
   logic                   r_overflow;
   logic                   r_measuring;

   logic                   w_rise;
   logic [COUNT_WIDTH:0]   w_sum;
   logic [COUNT_WIDTH-1:0] w_sum_sat;
   logic                   w_ovf_rise;

   always_comb begin
      w_rise     = r_sync2 & ~r_prev;
      w_sum      = {1'b0, r_edge_cnt} + {{COUNT_WIDTH{1'b0}}, w_rise};
      w_sum_sat  = (w_sum > MaxExt) ? MaxExt[COUNT_WIDTH-1:0] : w_sum[COUNT_WIDTH-1:0];
      // A rise arriving while the counter already sits at the limit is lost to saturation.
      w_ovf_rise = (r_edge_cnt == MaxExt[COUNT_WIDTH-1:0]) & w_rise;
   end

   always_ff @(posedge inputClock) begin
      if (reset) begin
         r_state     <= StIdle;
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_prev      <= 1'b0;
         r_gate_cnt  <= '0;
         r_edge_cnt  <= '0;
         r_win_ovf   <= 1'b0;
         r_freq      <= '0;
         r_valid     <= 1'b0;
         r_overflow  <= 1'b0;
         r_measuring <= 1'b0;
      end else begin
         // Input path runs in every state so a signal already high gives no false edge.
         r_sync1 <= measuredSignal;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_valid <= 1'b0;

         unique case (r_state)
            StIdle: begin
               r_gate_cnt <= '0;
               r_edge_cnt <= '0;
               r_win_ovf  <= 1'b0;
               if (enable) begin
                  r_state     <= StCount;
                  r_measuring <= 1'b1;
               end
            end
            StCount: begin
               if (!enable) begin
                  r_state     <= StIdle;
                  r_measuring <= 1'b0;
                  r_gate_cnt  <= '0;
                  r_edge_cnt  <= '0;
                  r_win_ovf   <= 1'b0;
               end else if (r_gate_cnt == GateLast) begin
                  // Publish and restart in the same edge: no dead time between windows.
                  r_freq     <= w_sum_sat;
                  r_overflow <= r_win_ovf | w_ovf_rise;
                  r_valid    <= 1'b1;
                  r_gate_cnt <= '0;
                  r_edge_cnt <= '0;
                  r_win_ovf  <= 1'b0;
               end else begin
                  r_gate_cnt <= r_gate_cnt + GateWidth'(1);
                  r_edge_cnt <= w_sum_sat;
                  r_win_ovf  <= r_win_ovf | w_ovf_rise;
               end
            end
         endcase
      end
   end

   assign frequencyValue = r_freq;
   assign valid          = r_valid;
   assign overflow       = r_overflow;
   assign measuring      = r_measuring;

endmodule

// File: tb/tb_frequency_meter.sv
// Bench for frequency_meter: directed scenarios plus randomized traffic, all compared
// every cycle against a window-counting reference model.
module tb_frequency_meter;

   localparam int unsigned G  = 100;
   localparam int unsigned MX = 30;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          sig;
   logic          en;
   logic [CW-1:0] freq;
   logic          valid;
   logic          ovf;
   logic          meas;

   int errors = 0;
   int checks = 0;

   frequency_meter #(
      .INPUT_CLOCK_SPEED(1000),
      .GATE_CYCLES      (G),
      .COUNT_WIDTH      (CW),
      .MAX_VALUE        (MX)
   ) dut (
      .inputClock    (clk),
      .reset         (rst),
      .measuredSignal(sig),
      .enable        (en),
      .frequencyValue(freq),
      .valid         (valid),
      .overflow      (ovf),
      .measuring     (meas)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- signal generator ----------------
   bit gen_on    = 1'b0;
   bit rand_mode = 1'b0;
   int hi_len    = 1;
   int lo_len    = 1;
   int left      = 1;

   always @(negedge clk) begin
      if (gen_on) begin
         if (left <= 1) begin
            sig = ~sig;
            if (rand_mode)
               left = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 25);
            else
               left = sig ? hi_len : lo_len;
         end else begin
            left--;
         end
      end
   end

   // ---------------- reference model ----------------
   // The DUT sees the input two samples late; a window counts the delayed 0->1 steps
   // over exactly G cycles, and the report is the true count clipped to MX.
   bit            model_live = 1'b0;
   bit            samp[3];
   bit            in_win;
   int            win_cyc;
   int            win_cnt;
   logic [CW-1:0] e_freq;
   bit            e_ovf;
   bit            e_valid;
   bit            e_meas;

   always @(posedge clk) begin
      bit rise;
      if (rst) begin
         samp       = '{0, 0, 0};
         in_win     = 0;
         win_cyc    = 0;
         win_cnt    = 0;
         e_freq     = '0;
         e_ovf      = 0;
         e_valid    = 0;
         e_meas     = 0;
         model_live = 1;
      end else if (model_live) begin
         rise    = samp[1] & ~samp[0];
         samp[0] = samp[1];
         samp[1] = samp[2];
         samp[2] = sig;
         e_valid = 0;
         if (!in_win) begin
            if (en) begin
               in_win  = 1;
               win_cyc = 0;
               win_cnt = 0;
            end
         end else if (!en) begin
            in_win = 0;
         end else begin
            win_cnt += int'(rise);
            win_cyc++;
            if (win_cyc == G) begin
               e_freq  = CW'((win_cnt > MX) ? MX : win_cnt);
               e_ovf   = (win_cnt > MX);
               e_valid = 1;
               win_cyc = 0;
               win_cnt = 0;
            end
         end
         e_meas = in_win;
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("valid", valid, e_valid);
         check("frequencyValue", freq, e_freq);
         check("overflow", ovf, e_ovf);
         check("measuring", meas, e_meas);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_valid(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (valid !== 1'b1 && n < limit);
      if (valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_valid: no valid within %0d cycles", limit);
      end
   endtask

   task automatic set_period(input int half);
      hi_len = half;
      lo_len = half;
   endtask

   int n;
   int saw;

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      sig = 1'b0;
      set_period(1);
      gen_on = 1'b1;

      // Reset with the input toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_freq", freq, 0);
         check("rst_valid", valid, 0);
         check("rst_ovf", ovf, 0);
         check("rst_meas", meas, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_freq", freq, 0);
      check("post_rst_meas", meas, 0);

      // Steady measurement, period 10
      set_period(5);
      repeat (20) @(negedge clk);
      check("idle_meas", meas, 0);
      en = 1'b1;
      wait_valid(400, n);
      check("first_valid_latency", n, 101);
      check("steady_freq1", freq, 10);
      check("steady_ovf1", ovf, 0);
      wait_valid(400, n);
      check("valid_spacing", n, 100);
      check("steady_freq2", freq, 10);
      @(negedge clk);
      check("valid_width", valid, 0);
      check("meas_across_boundary", meas, 1);

      // Saturation at period 2, then recovery at period 20
      set_period(1);
      repeat (3) wait_valid(400, n);
      check("sat_freq", freq, 30);
      check("sat_ovf", ovf, 1);
      set_period(10);
      repeat (3) wait_valid(400, n);
      check("p20_freq", freq, 5);
      check("p20_ovf", ovf, 0);

      // Abort mid-window
      set_period(5);
      repeat (3) wait_valid(400, n);
      check("pre_abort_freq", freq, 10);
      repeat (50) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("abort_meas", meas, 0);
      saw = 0;
      repeat (150) begin
         @(negedge clk);
         if (valid === 1'b1) saw++;
      end
      check("abort_no_valid", saw, 0);
      check("abort_hold_freq", freq, 10);
      en = 1'b1;
      wait_valid(400, n);
      check("reenable_latency", n, 101);
      check("reenable_freq", freq, 10);

      // Boundary: last rise detected on the final gate cycle
      en     = 1'b0;
      gen_on = 1'b0;
      @(negedge clk);
      sig = 1'b0;
      repeat (10) @(negedge clk);
      for (int v = 0; v < 2; v++) begin
         en = 1'b1;
         for (int r = 1; r <= 101; r++) begin
            @(negedge clk);
            sig = (r <= 85 && (r - 1) % 3 == 0) || r == 98 || (v == 1 && r == 91);
         end
         check("boundary_valid", valid, 1);
         check("boundary_freq", freq, 30);
         check("boundary_ovf", ovf, v);
         en = 1'b0;
         repeat (10) @(negedge clk);
      end

      // Static-high input, then a single transition mid-window
      sig = 1'b1;
      repeat (10) @(negedge clk);
      en = 1'b1;
      wait_valid(400, n);
      check("static_freq1", freq, 0);
      check("static_ovf1", ovf, 0);
      wait_valid(400, n);
      check("static_freq2", freq, 0);
      repeat (30) @(negedge clk);
      sig = 1'b0;
      repeat (10) @(negedge clk);
      sig = 1'b1;
      wait_valid(400, n);
      check("single_edge_freq", freq, 1);
      wait_valid(400, n);
      check("after_single_freq", freq, 0);

      // Randomized traffic with enable drops and occasional resets
      rand_mode = 1'b1;
      gen_on    = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst = 1'b0;
         if ($urandom_range(0, 399) == 0) en = ~en;
         else if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
         if ($urandom_range(0, 1499) == 0) rst = 1'b1;
      end
      rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
